// File: rtl/pc_flow_ctrl.sv
//==============================================================================
// Module   : pc_flow_ctrl
// Brief    : Program-counter controller for the RV-MAGIC core. Handles
//            sequential fetch, stall hold, jump/branch redirect, flush
//            pulses and the fetch-valid qualifier.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_flow_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_ADDR   = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            jumpOrBranch,
    input  logic            jalr,
    input  logic [XLEN-1:0] pcRelTarget,
    input  logic [XLEN-1:0] jalrTarget,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            fetch_valid_o,
    output logic            flush_o,
    output logic            misaligned_o
);

    localparam logic [1:0]      c_BOOT       = 2'd0;
    localparam logic [1:0]      c_RUN        = 2'd1;
    localparam logic [1:0]      c_FLUSH      = 2'd2;
    localparam logic [2:0]      c_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0] c_BIT0_CLR   = ~XLEN'(1);
    localparam logic [XLEN-1:0] c_WORD_CLR   = ~XLEN'(3);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [2:0]      r_flushCnt;
    logic            r_misaligned;

    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pcPlus4;
    logic            w_advance;

    always_comb begin
        w_target  = jalr ? (jalrTarget & c_BIT0_CLR) : pcRelTarget;
        w_pcPlus4 = r_pc + XLEN'(4);
        w_advance = imem_ready & ~stall_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_BOOT;
            r_pc         <= RESET_ADDR;
            r_flushCnt   <= 3'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            case (r_state)
                c_BOOT: begin
                    r_state <= c_RUN;
                end
                c_RUN: begin
                    // Redirect wins over stall and a busy instruction memory.
                    if (jumpOrBranch) begin
                        r_pc         <= w_target & c_WORD_CLR;
                        r_misaligned <= w_target[1];
                        r_flushCnt   <= c_FLUSH_LOAD;
                        r_state      <= c_FLUSH;
                    end else if (w_advance) begin
                        r_pc <= w_pcPlus4;
                    end
                end
                c_FLUSH: begin
                    // Redirect requests here come from squashed instructions.
                    if (w_advance) begin
                        r_pc <= w_pcPlus4;
                    end
                    if (r_flushCnt == 3'd0) begin
                        r_state <= c_RUN;
                    end else begin
                        r_flushCnt <= r_flushCnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= c_BOOT;
                end
            endcase
        end
    end

    assign pc_o          = r_pc;
    assign pc_plus4_o    = w_pcPlus4;
    assign fetch_valid_o = (r_state != c_BOOT);
    assign flush_o       = (r_state == c_FLUSH);
    assign misaligned_o  = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_pc_flow_ctrl.sv
//==============================================================================
// Module   : tb_pc_flow_ctrl
// Brief    : Self-checking bench for pc_flow_ctrl against a cycle-level model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_flow_ctrl;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_ADDR   = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        jumpOrBranch;
    logic        jalr;
    logic [31:0] pcRelTarget;
    logic [31:0] jalrTarget;
    logic        imem_ready;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic        misaligned_o;

    int vectors;
    int miscompares;

    // Reference model state: boot flag, remaining flush cycles, PC, pulse.
    bit          mBooting;
    int          mFlushLeft;
    logic [31:0] mPc;
    bit          mMis;

    pc_flow_ctrl #(
        .XLEN         (XLEN),
        .RESET_ADDR   (RESET_ADDR),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .jumpOrBranch  (jumpOrBranch),
        .jalr          (jalr),
        .pcRelTarget   (pcRelTarget),
        .jalrTarget    (jalrTarget),
        .imem_ready    (imem_ready),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .fetch_valid_o (fetch_valid_o),
        .flush_o       (flush_o),
        .misaligned_o  (misaligned_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mBooting   = 1'b1;
        mFlushLeft = 0;
        mPc        = RESET_ADDR;
        mMis       = 1'b0;
    endtask

    // Apply one cycle of inputs, check outputs at the falling edge, then
    // advance the model across the rising edge.
    task automatic step(input bit st, input bit jb, input bit jl, input bit ir,
                        input logic [31:0] rel, input logic [31:0] jt);
        logic [31:0] tgt;
        stall_i      = st;
        jumpOrBranch = jb;
        jalr         = jl;
        imem_ready   = ir;
        pcRelTarget  = rel;
        jalrTarget   = jt;
        @(negedge clk);
        chk("pc", pc_o, mPc);
        chk("pc_plus4", pc_plus4_o, mPc + 32'd4);
        chk("fetch_valid", {31'd0, fetch_valid_o}, {31'd0, !mBooting});
        chk("flush", {31'd0, flush_o}, {31'd0, mFlushLeft > 0});
        chk("misaligned", {31'd0, misaligned_o}, {31'd0, mMis});
        mMis = 1'b0;
        if (mBooting) begin
            mBooting = 1'b0;
        end else if (mFlushLeft > 0) begin
            mFlushLeft--;
            if (ir && !st) mPc = mPc + 32'd4;
        end else if (jb) begin
            tgt        = jl ? {jt[31:1], 1'b0} : rel;
            mMis       = tgt[1];
            mPc        = {tgt[31:2], 2'b00};
            mFlushLeft = FLUSH_CYCLES;
        end else if (ir && !st) begin
            mPc = mPc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        stall_i      = 1'b0;
        jumpOrBranch = 1'b0;
        jalr         = 1'b0;
        imem_ready   = 1'b1;
        pcRelTarget  = 32'h0;
        jalrTarget   = 32'h0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc_o, RESET_ADDR);
        chk("rst_fetch_valid", {31'd0, fetch_valid_o}, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned_o}, 32'd0);
        rst_n = 1'b1;

        // Boot cycle then sequential fetch 0x0, 0x4, 0x8.
        run(4);
        for (int i = 0; i < 20 && mPc != 32'h10; i++) run(1);
        chk("reach_0x10", pc_o, 32'h10);

        // Stall hold, then imem_ready hold.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 32'h0, 32'h0);
        run(1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0, 32'h0);
        run(1);
        for (int i = 0; i < 20 && mPc != 32'h20; i++) run(1);
        chk("reach_0x20", pc_o, 32'h20);

        // Branch with stall asserted, second branch ignored inside flush.
        step(1, 1, 0, 1, 32'h100, 32'h0);
        step(0, 1, 0, 1, 32'h400, 32'h0);
        run(3);

        // JALR targets with and without bit 1 set; jalr alone does nothing.
        step(0, 1, 1, 1, 32'h0, 32'h203);
        run(3);
        step(0, 1, 1, 1, 32'h0, 32'h201);
        run(3);
        step(0, 0, 1, 1, 32'h0, 32'h800);
        run(1);

        // Reset in the middle of a flush drops everything at once.
        step(0, 1, 0, 1, 32'h300, 32'h0);
        chk("pre_rst_flush", {31'd0, flush_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc_o, RESET_ADDR);
        chk("midrst_flush", {31'd0, flush_o}, 32'd0);
        chk("midrst_misaligned", {31'd0, misaligned_o}, 32'd0);
        chk("midrst_fetch_valid", {31'd0, fetch_valid_o}, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(2);

        // Wrap-around across the top of the address space.
        step(0, 1, 0, 1, 32'hFFFF_FFF0, 32'h0);
        run(4);
        chk("wrap_pc", pc_o, 32'h0000_0000);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
